// File: rtl/mcb_read_checker.sv
// -----------------------------------------------------------------------------
// mcb_read_checker
//
// Read-side test engine for a DDR3 MCB user port. Walks an address window in
// fixed bursts, issues one read command per burst and compares every returned
// beat against an expected-data pattern. Reports a saturating error count,
// a capture of the first miscompare, the number of completed passes and a
// sticky flag for read data that arrives when no burst is outstanding.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   i_start             one-cycle pulse, begins a run from IDLE or DONE
//   i_stop              level, finish the current burst then go to DONE
//   i_continuous        1 = repeat passes forever, 0 = a single pass
//   i_mode              0 AA/55, 1 address+beat, 2 LFSR, 3 walking one
//   o_rd_cmd_en         read command request
//   i_rd_cmd_done       command accepted by the MCB
//   o_rd_addr           burst start address
//   o_rd_len            burst length (constant BL)
//   i_rd_rdy, i_rd_data read data strobe and data
//   o_busy, o_done      run in progress / run finished (held until next start)
//   o_err_flag          sticky, any miscompare this run
//   o_err_cnt           saturating miscompare count
//   o_first_err_*       burst address, beat index and data of first miscompare
//   o_pass_cnt          completed full passes (wraps)
//   o_spurious          sticky, read data seen outside a data phase
// -----------------------------------------------------------------------------
module mcb_read_checker #(
    parameter int             DW         = 32,
    parameter int             AW         = 30,
    parameter int             BL         = 64,
    parameter logic [AW-1:0]  ADDR_INC   = 30'h400,
    parameter logic [AW-1:0]  START_ADDR = 30'h0,
    parameter logic [AW-1:0]  END_ADDR   = 30'h0FFFFC00,
    parameter int             ERR_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_continuous,
    input  logic [1:0]       i_mode,
    output logic             o_rd_cmd_en,
    input  logic             i_rd_cmd_done,
    output logic [AW-1:0]    o_rd_addr,
    output logic [6:0]       o_rd_len,
    input  logic             i_rd_rdy,
    input  logic [DW-1:0]    i_rd_data,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err_flag,
    output logic [ERR_W-1:0] o_err_cnt,
    output logic [AW-1:0]    o_first_err_addr,
    output logic [6:0]       o_first_err_beat,
    output logic [DW-1:0]    o_first_err_data,
    output logic [15:0]      o_pass_cnt,
    output logic             o_spurious
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_NEXT,
        ST_DONE
    } state_t;

    // Galois form of x^32 + x^22 + x^2 + x + 1, shifting right.
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
    localparam logic [6:0]  LAST_BEAT = 7'(BL - 1);

    state_t            r_state;
    logic [AW-1:0]     r_addr;
    logic [1:0]        r_mode;
    logic [6:0]        r_beat;
    logic [31:0]       r_lfsr;
    logic              r_rd_cmd_en;
    logic              r_busy;
    logic              r_done;
    logic              r_err_flag;
    logic [ERR_W-1:0]  r_err_cnt;
    logic [AW-1:0]     r_first_err_addr;
    logic [6:0]        r_first_err_beat;
    logic [DW-1:0]     r_first_err_data;
    logic [15:0]       r_pass_cnt;
    logic              r_spurious;

    logic [31:0]       w_addr_word;
    logic [31:0]       w_seed;
    logic [31:0]       w_lfsr_next;
    logic [31:0]       w_pattern;
    logic [DW-1:0]     w_expected;
    logic              w_miscompare;
    logic              w_at_end;
    logic              w_go_done;

    // Address zero-extended (or truncated) to the 32-bit pattern word.
    assign w_addr_word = 32'(r_addr);
    // An all-zero Galois LFSR never leaves zero, so substitute 1.
    assign w_seed      = (w_addr_word == 32'h0) ? 32'h1 : w_addr_word;
    assign w_lfsr_next = r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_MASK) : (r_lfsr >> 1);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case can leave it unassigned and infer a latch.
        w_pattern = 32'h0;
        case (r_mode)
            2'd0:    w_pattern = r_beat[0] ? 32'h5555_5555 : 32'hAAAA_AAAA;
            2'd1:    w_pattern = w_addr_word + 32'(r_beat);
            2'd2:    w_pattern = r_lfsr;
            default: w_pattern = 32'h1 << r_beat[4:0];
        endcase
    end

    // The 32-bit word repeats across the data bus; widths that are not a
    // multiple of 32 take the low bits of the last copy.
    always_comb begin
        w_expected = '0;
        for (int i = 0; i < DW; i++) begin
            w_expected[i] = w_pattern[i % 32];
        end
    end

    assign w_miscompare = (i_rd_data != w_expected);
    assign w_at_end     = (r_addr == END_ADDR);
    // At the end of the window a single-pass run finishes by itself;
    // elsewhere only stop ends the run.
    assign w_go_done    = w_at_end ? (i_stop || !i_continuous) : i_stop;

    // NOTE: all state is updated with non-blocking assignments so every
    // register sees the pre-edge values of the others, as in hardware.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state          <= ST_IDLE;
            r_addr           <= START_ADDR;
            r_mode           <= 2'd0;
            r_beat           <= 7'd0;
            r_lfsr           <= 32'h0;
            r_rd_cmd_en      <= 1'b0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_err_flag       <= 1'b0;
            r_err_cnt        <= '0;
            r_first_err_addr <= '0;
            r_first_err_beat <= 7'd0;
            r_first_err_data <= '0;
            r_pass_cnt       <= 16'd0;
            r_spurious       <= 1'b0;
        end else begin
            if (i_rd_rdy && (r_state != ST_DATA)) begin
                r_spurious <= 1'b1;
            end

            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        r_state          <= ST_CMD;
                        r_addr           <= START_ADDR;
                        r_mode           <= i_mode;
                        r_rd_cmd_en      <= 1'b1;
                        r_busy           <= 1'b1;
                        r_done           <= 1'b0;
                        r_err_flag       <= 1'b0;
                        r_err_cnt        <= '0;
                        r_first_err_addr <= '0;
                        r_first_err_beat <= 7'd0;
                        r_first_err_data <= '0;
                        r_pass_cnt       <= 16'd0;
                        // Overrides a spurious strobe coinciding with start.
                        r_spurious       <= 1'b0;
                    end
                end

                ST_CMD: begin
                    if (i_rd_cmd_done) begin
                        r_state     <= ST_DATA;
                        r_rd_cmd_en <= 1'b0;
                        r_beat      <= 7'd0;
                        r_lfsr      <= w_seed;
                    end
                end

                ST_DATA: begin
                    if (i_rd_rdy) begin
                        if (w_miscompare) begin
                            if (r_err_cnt != '1) begin
                                r_err_cnt <= r_err_cnt + 1'b1;
                            end
                            if (!r_err_flag) begin
                                r_err_flag       <= 1'b1;
                                r_first_err_addr <= r_addr;
                                r_first_err_beat <= r_beat;
                                r_first_err_data <= i_rd_data;
                            end
                        end
                        r_beat <= r_beat + 7'd1;
                        r_lfsr <= w_lfsr_next;
                        if (r_beat == LAST_BEAT) begin
                            r_state <= ST_NEXT;
                        end
                    end
                end

                ST_NEXT: begin
                    if (w_at_end) begin
                        r_addr     <= START_ADDR;
                        r_pass_cnt <= r_pass_cnt + 16'd1;
                    end else begin
                        r_addr <= r_addr + ADDR_INC;
                    end
                    if (w_go_done) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state     <= ST_CMD;
                        r_rd_cmd_en <= 1'b1;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_rd_cmd_en      = r_rd_cmd_en;
    assign o_rd_addr        = r_addr;
    assign o_rd_len         = 7'(BL);
    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign o_err_flag       = r_err_flag;
    assign o_err_cnt        = r_err_cnt;
    assign o_first_err_addr = r_first_err_addr;
    assign o_first_err_beat = r_first_err_beat;
    assign o_first_err_data = r_first_err_data;
    assign o_pass_cnt       = r_pass_cnt;
    assign o_spurious       = r_spurious;

endmodule

// File: tb/tb_mcb_read_checker.sv
// -----------------------------------------------------------------------------
// tb_mcb_read_checker
//
// Self-checking bench for mcb_read_checker. A behavioural MCB answers read
// commands, a pattern model computes every expected beat from the mode
// rules, and a scoreboard tracks error count and first-failure capture.
// Directed runs come from a vector table; randomized runs use the model.
// -----------------------------------------------------------------------------
module tb_mcb_read_checker;

    localparam int            DW    = 64;
    localparam int            AW    = 30;
    localparam int            BL    = 64;
    localparam int            ERR_W = 4;
    localparam int            ERR_MAX = (1 << ERR_W) - 1;
    localparam logic [AW-1:0] INC   = 30'h400;
    localparam logic [AW-1:0] START = 30'h0;
    localparam logic [AW-1:0] LAST  = 30'h800;
    localparam int            NBURST = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             i_start, i_stop, i_continuous;
    logic [1:0]       i_mode;
    logic             o_rd_cmd_en;
    logic             i_rd_cmd_done;
    logic [AW-1:0]    o_rd_addr;
    logic [6:0]       o_rd_len;
    logic             i_rd_rdy;
    logic [DW-1:0]    i_rd_data;
    logic             o_busy, o_done, o_err_flag;
    logic [ERR_W-1:0] o_err_cnt;
    logic [AW-1:0]    o_first_err_addr;
    logic [6:0]       o_first_err_beat;
    logic [DW-1:0]    o_first_err_data;
    logic [15:0]      o_pass_cnt;
    logic             o_spurious;

    always #5 clk = ~clk;

    mcb_read_checker #(
        .DW(DW), .AW(AW), .BL(BL), .ADDR_INC(INC),
        .START_ADDR(START), .END_ADDR(LAST), .ERR_W(ERR_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_stop(i_stop),
        .i_continuous(i_continuous), .i_mode(i_mode),
        .o_rd_cmd_en(o_rd_cmd_en), .i_rd_cmd_done(i_rd_cmd_done),
        .o_rd_addr(o_rd_addr), .o_rd_len(o_rd_len),
        .i_rd_rdy(i_rd_rdy), .i_rd_data(i_rd_data),
        .o_busy(o_busy), .o_done(o_done), .o_err_flag(o_err_flag),
        .o_err_cnt(o_err_cnt), .o_first_err_addr(o_first_err_addr),
        .o_first_err_beat(o_first_err_beat), .o_first_err_data(o_first_err_data),
        .o_pass_cnt(o_pass_cnt), .o_spurious(o_spurious)
    );

    typedef struct {
        logic [1:0]    mode;
        int            cmd_delay;
        bit            c_all;
        logic [AW-1:0] c_addr;
        int            c_beat;
        logic [DW-1:0] c_val;
        int            exp_err;
        logic [AW-1:0] exp_faddr;
        int            exp_fbeat;
        logic [DW-1:0] exp_fdata;
    } vec_t;

    vec_t vecs[10];

    int n_cmp = 0;
    int n_mis = 0;

    // Stimulus configuration shared by the MCB model.
    logic [1:0]    mode_cur;
    bit            c_all;
    logic [AW-1:0] c_addr;
    int            c_beat;
    logic [DW-1:0] c_val;
    int            c_rand_pct;
    int            gap_pct;
    int            stop_beat;
    int            rst_beat;
    bit            poke;
    logic [AW-1:0] cmd_q[$];

    // Scoreboard.
    int            m_err;
    bit            m_flag;
    logic [AW-1:0] m_faddr;
    int            m_fbeat;
    logic [DW-1:0] m_fdata;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [1:0] m, input logic [AW-1:0] a, input int b);
        logic [31:0] s;
        case (m)
            2'd0: return (b % 2 == 1) ? 32'h5555_5555 : 32'hAAAA_AAAA;
            2'd1: return {2'b00, a} + 32'(b);
            2'd2: begin
                s = {2'b00, a};
                if (s == 32'h0) s = 32'h1;
                for (int i = 0; i < b; i++) s = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
                return s;
            end
            default: return 32'h1 << (b % 32);
        endcase
    endfunction

    task automatic model_clear();
        m_err = 0; m_flag = 0; m_faddr = '0; m_fbeat = 0; m_fdata = '0;
        cmd_q.delete();
    endtask

    task automatic model_beat(input logic [AW-1:0] a, input int b, input logic [DW-1:0] d, input logic [DW-1:0] e);
        if (d !== e) begin
            if (m_err < ERR_MAX) m_err++;
            if (!m_flag) begin
                m_flag = 1; m_faddr = a; m_fbeat = b; m_fdata = d;
            end
        end
    endtask

    // Answer one read command: wait for it, optionally delay acceptance,
    // then return BL beats with random idle gaps.
    task automatic serve_burst(input int cmd_delay, output bit ok);
        int n;
        int b;
        bit hold_ok;
        logic [AW-1:0] a;
        logic [DW-1:0] e, d;
        ok = 1;
        n = 0;
        while (!o_rd_cmd_en && n < 100) begin tick(); n++; end
        check("cmd_en_seen", 64'(o_rd_cmd_en), 64'(1));
        if (!o_rd_cmd_en) begin ok = 0; return; end
        a = o_rd_addr;
        cmd_q.push_back(a);
        check("rd_len", 64'(o_rd_len), 64'(BL));
        hold_ok = 1;
        for (int i = 0; i < cmd_delay; i++) begin
            tick();
            if (!o_rd_cmd_en || o_rd_addr !== a) hold_ok = 0;
        end
        if (cmd_delay > 0) check("cmd_hold", 64'(hold_ok), 64'(1));
        i_rd_cmd_done = 1'b1;
        tick();
        i_rd_cmd_done = 1'b0;
        check("cmd_en_drop", 64'(o_rd_cmd_en), 64'(0));
        b = 0;
        while (b < BL) begin
            if (b == rst_beat) begin
                i_rd_rdy = 1'b0;
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
                ok = 0;
                return;
            end
            if (b == stop_beat) i_stop = 1'b1;
            if (int'($urandom_range(99)) < gap_pct) begin
                i_rd_rdy = 1'b0;
                i_start = 1'b0;
                i_rd_cmd_done = 1'b0;
                tick();
                continue;
            end
            e = {2{exp_word(mode_cur, a, b)}};
            d = e;
            if (c_all) d = ~e;
            if (a == c_addr && b == c_beat) d = c_val;
            if (int'($urandom_range(99)) < c_rand_pct) d = e ^ (64'h1 << $urandom_range(63));
            model_beat(a, b, d, e);
            i_rd_rdy = 1'b1;
            i_rd_data = d;
            // Start while busy and command-done outside CMD must be ignored.
            i_start = poke && (b == 10);
            i_rd_cmd_done = poke && (b == 20);
            tick();
            b++;
        end
        i_rd_rdy = 1'b0;
        i_start = 1'b0;
        i_rd_cmd_done = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!o_done && n < 50) begin tick(); n++; end
        check("done", 64'(o_done), 64'(1));
    endtask

    task automatic run(input logic [1:0] md, input bit cont, input int nb, input int cmd_delay, output bit ok);
        ok = 1;
        mode_cur = md;
        model_clear();
        i_mode = md;
        i_continuous = cont;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        // The mode must have been latched at start.
        i_mode = ~md;
        check("busy_after_start", 64'(o_busy), 64'(1));
        for (int k = 0; k < nb; k++) begin
            serve_burst(cmd_delay, ok);
            if (!ok) return;
        end
        wait_done();
    endtask

    task automatic check_results(input int exp_err, input logic [AW-1:0] faddr, input int fbeat,
                                 input logic [DW-1:0] fdata, input int passes);
        check("err_cnt", 64'(o_err_cnt), 64'(exp_err));
        check("err_flag", 64'(o_err_flag), 64'(exp_err != 0));
        check("first_err_addr", 64'(o_first_err_addr), 64'(faddr));
        check("first_err_beat", 64'(o_first_err_beat), 64'(fbeat));
        check("first_err_data", o_first_err_data, fdata);
        check("pass_cnt", 64'(o_pass_cnt), 64'(passes));
        check("busy_at_done", 64'(o_busy), 64'(0));
        check("cmd_en_at_done", 64'(o_rd_cmd_en), 64'(0));
        check("spurious", 64'(o_spurious), 64'(0));
        check("cmd_count", 64'(cmd_q.size()), 64'(NBURST));
        for (int k = 0; k < cmd_q.size() && k < NBURST; k++) begin
            check("cmd_addr", 64'(cmd_q[k]), 64'(START + AW'(k) * INC));
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_cmd_en"}, 64'(o_rd_cmd_en), 64'(0));
        check({tag, "_rd_addr"}, 64'(o_rd_addr), 64'(START));
        check({tag, "_rd_len"}, 64'(o_rd_len), 64'(BL));
        check({tag, "_busy"}, 64'(o_busy), 64'(0));
        check({tag, "_done"}, 64'(o_done), 64'(0));
        check({tag, "_err_flag"}, 64'(o_err_flag), 64'(0));
        check({tag, "_err_cnt"}, 64'(o_err_cnt), 64'(0));
        check({tag, "_faddr"}, 64'(o_first_err_addr), 64'(0));
        check({tag, "_fbeat"}, 64'(o_first_err_beat), 64'(0));
        check({tag, "_fdata"}, o_first_err_data, 64'(0));
        check({tag, "_pass_cnt"}, 64'(o_pass_cnt), 64'(0));
        check({tag, "_spurious"}, 64'(o_spurious), 64'(0));
    endtask

    task automatic clear_cfg();
        c_all = 0; c_addr = '0; c_beat = -1; c_val = '0;
        c_rand_pct = 0; gap_pct = 10; stop_beat = -1; rst_beat = -1; poke = 0;
    endtask

    initial begin
        bit ok;
        int n;

        //               mode  dly all c_addr    beat c_val                    err     faddr     fbeat fdata
        vecs[0] = '{2'd0, 0,  1'b0, 30'h000, -1, 64'h0,                     0,      30'h000, 0,  64'h0};
        vecs[1] = '{2'd1, 0,  1'b0, 30'h400, 5,  64'h0,                     1,      30'h400, 5,  64'h0};
        vecs[2] = '{2'd2, 0,  1'b1, 30'h000, -1, 64'h0,                     ERR_MAX, 30'h000, 0,  64'hFFFF_FFFE_FFFF_FFFE};
        vecs[3] = '{2'd3, 10, 1'b0, 30'h000, -1, 64'h0,                     0,      30'h000, 0,  64'h0};
        vecs[4] = '{2'd3, 0,  1'b0, 30'h800, 63, 64'h0,                     1,      30'h800, 63, 64'h0};
        vecs[5] = '{2'd0, 2,  1'b0, 30'h000, 0,  64'hAAAA_AAAA_AAAA_AAAA,   0,      30'h000, 0,  64'h0};
        vecs[6] = '{2'd2, 0,  1'b0, 30'h400, 1,  64'h0,                     1,      30'h400, 1,  64'h0};
        vecs[7] = '{2'd0, 0,  1'b0, 30'h400, 0,  64'h5555_5555_5555_5555,   1,      30'h400, 0,  64'h5555_5555_5555_5555};
        vecs[8] = '{2'd1, 1,  1'b0, 30'h000, 2,  64'h0000_0000_0000_0002,   1,      30'h000, 2,  64'h0000_0000_0000_0002};
        vecs[9] = '{2'd1, 0,  1'b1, 30'h000, -1, 64'h0,                     ERR_MAX, 30'h000, 0,  64'hFFFF_FFFF_FFFF_FFFF};

        rst_n = 1'b0;
        i_start = 0; i_stop = 0; i_continuous = 0; i_mode = 0;
        i_rd_cmd_done = 0; i_rd_rdy = 0; i_rd_data = '0;
        clear_cfg();
        tick();
        tick();
        check_reset_state("por");
        rst_n = 1'b1;
        tick();

        // Directed single-pass runs from the vector table.
        for (int v = 0; v < 10; v++) begin
            clear_cfg();
            c_all = vecs[v].c_all; c_addr = vecs[v].c_addr;
            c_beat = vecs[v].c_beat; c_val = vecs[v].c_val;
            poke = (v % 2 == 1);
            run(vecs[v].mode, 1'b0, NBURST, vecs[v].cmd_delay, ok);
            check_results(vecs[v].exp_err, vecs[v].exp_faddr, vecs[v].exp_fbeat, vecs[v].exp_fdata, 1);
            tick();
        end

        // Randomized single-pass runs against the scoreboard.
        for (int r = 0; r < 6; r++) begin
            clear_cfg();
            c_rand_pct = $urandom_range(0, 6);
            gap_pct = $urandom_range(0, 30);
            poke = 1;
            run(2'($urandom_range(3)), 1'b0, NBURST, $urandom_range(0, 4), ok);
            check_results(m_err, m_faddr, m_fbeat, m_fdata, 1);
        end

        // Continuous run stopped in the first burst of the second pass.
        clear_cfg();
        mode_cur = 2'd1;
        model_clear();
        i_mode = 2'd1; i_continuous = 1'b1;
        i_start = 1'b1; tick(); i_start = 1'b0;
        for (int k = 0; k < NBURST; k++) serve_burst(0, ok);
        stop_beat = 20;
        serve_burst(0, ok);
        stop_beat = -1;
        wait_done();
        i_stop = 1'b0;
        check("stop_pass_cnt", 64'(o_pass_cnt), 64'(1));
        check("stop_cmd_count", 64'(cmd_q.size()), 64'(NBURST + 1));
        check("stop_wrap_addr", 64'(cmd_q[NBURST]), 64'(START));
        check("stop_busy", 64'(o_busy), 64'(0));
        check("stop_err_cnt", 64'(o_err_cnt), 64'(0));
        check("spurious_before", 64'(o_spurious), 64'(0));
        i_rd_rdy = 1'b1; tick(); i_rd_rdy = 1'b0; tick();
        check("spurious_in_done", 64'(o_spurious), 64'(1));
        check("done_held", 64'(o_done), 64'(1));

        // Reset while a command is pending.
        i_mode = 2'd0; i_continuous = 1'b0;
        i_start = 1'b1; tick(); i_start = 1'b0;
        n = 0;
        while (!o_rd_cmd_en && n < 20) begin tick(); n++; end
        check("cmd_en_before_rst", 64'(o_rd_cmd_en), 64'(1));
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        check_reset_state("rst_cmd");

        // Reset at beat 30 of a burst that already saw a miscompare.
        clear_cfg();
        c_addr = START; c_beat = 3; c_val = '0; rst_beat = 30;
        run(2'd1, 1'b0, NBURST, 0, ok);
        check("rst_data_aborted", 64'(ok), 64'(0));
        check_reset_state("rst_data");

        // Clean rerun after reset.
        clear_cfg();
        tick();
        run(2'd2, 1'b0, NBURST, 1, ok);
        check_results(0, '0, 0, '0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
